// File: rtl/exu_bjp_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exu_bjp_resolve                                                 |
// | Brief    : Branch/jump resolution; raises an IFU redirect on bxx mispredict|
// |            and hands PC + offset operands to the IFU target adder.         |
// |            Optional mispredict counter: define E203_BJP_MISPRED_CNT_EN.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

`ifndef PC_Size
`define PC_Size 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module exu_bjp_resolve (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [`PC_Size-1:0] i_pc,
    input  logic                i_bxx,
    input  logic                i_jump,
    input  logic                i_pred_taken,
    input  logic                i_cmp_res,
    input  logic [`XLEN-1:0]    i_imm,
    input  logic                i_rv32,
    output logic                pipe_flush_req,
    input  logic                pipe_flush_ack,
    output logic [`PC_Size-1:0] pipe_flush_add_op1,
    output logic [`PC_Size-1:0] pipe_flush_add_op2,
    output logic                o_mispred,
    output logic [31:0]         o_mispred_cnt
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_flush = 1'b1;

    localparam logic [`PC_Size-1:0] c_step_32 = `PC_Size'(4);
    localparam logic [`PC_Size-1:0] c_step_16 = `PC_Size'(2);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                w_accept;
    logic                w_mispred;
    logic [`PC_Size-1:0] w_op2_nxt;
    logic [`PC_Size-1:0] r_op1;
    logic [`PC_Size-1:0] r_op2;
    logic                r_mispred;
    logic                w_unused;

    // Jumps are always predicted taken with an exact target, so they never
    // redirect here; i_jump is only carried along the interface.
    assign w_unused = i_jump;

    assign i_ready   = (r_state == c_st_idle);
    assign w_accept  = i_valid & i_ready;
    assign w_mispred = w_accept & i_bxx & (i_pred_taken ^ i_cmp_res);

    // Taken-but-predicted-not-taken redirects to pc+imm, otherwise to the
    // fall-through address; the IFU adder does the actual sum.
    assign w_op2_nxt = i_cmp_res ? i_imm[`PC_Size-1:0]
                                 : (i_rv32 ? c_step_32 : c_step_16);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_mispred)      w_state_nxt = c_st_flush;
            c_st_flush: if (pipe_flush_ack) w_state_nxt = c_st_idle;
            default:                        w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_op1     <= '0;
            r_op2     <= '0;
            r_mispred <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mispred <= w_mispred;
            if (w_mispred) begin
                r_op1 <= i_pc;
                r_op2 <= w_op2_nxt;
            end
        end
    end

    assign pipe_flush_req     = (r_state == c_st_flush);
    assign pipe_flush_add_op1 = r_op1;
    assign pipe_flush_add_op2 = r_op2;
    assign o_mispred          = r_mispred;

`ifdef E203_BJP_MISPRED_CNT_EN
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mispred_cnt <= 32'd0;
        end else if (w_mispred && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign o_mispred_cnt = r_mispred_cnt;
`else
    assign o_mispred_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exu_bjp_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_exu_bjp_resolve                                              |
// | Brief    : Directed table-driven bench for exu_bjp_resolve plus sequences  |
// |            for stall, ack timing, back-to-back accepts and reset in FLUSH. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

`ifndef PC_Size
`define PC_Size 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_exu_bjp_resolve;

    localparam int PCW = `PC_Size;
    localparam int XW  = `XLEN;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_valid;
    logic           i_ready;
    logic [PCW-1:0] i_pc;
    logic           i_bxx;
    logic           i_jump;
    logic           i_pred_taken;
    logic           i_cmp_res;
    logic [XW-1:0]  i_imm;
    logic           i_rv32;
    logic           pipe_flush_req;
    logic           pipe_flush_ack;
    logic [PCW-1:0] pipe_flush_add_op1;
    logic [PCW-1:0] pipe_flush_add_op2;
    logic           o_mispred;
    logic [31:0]    o_mispred_cnt;

    always #5 clk = ~clk;

    exu_bjp_resolve u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_valid            (i_valid),
        .i_ready            (i_ready),
        .i_pc               (i_pc),
        .i_bxx              (i_bxx),
        .i_jump             (i_jump),
        .i_pred_taken       (i_pred_taken),
        .i_cmp_res          (i_cmp_res),
        .i_imm              (i_imm),
        .i_rv32             (i_rv32),
        .pipe_flush_req     (pipe_flush_req),
        .pipe_flush_ack     (pipe_flush_ack),
        .pipe_flush_add_op1 (pipe_flush_add_op1),
        .pipe_flush_add_op2 (pipe_flush_add_op2),
        .o_mispred          (o_mispred),
        .o_mispred_cnt      (o_mispred_cnt)
    );

    typedef struct {
        logic           bxx;
        logic           jump;
        logic           pred;
        logic           cmp;
        logic           rv32;
        logic [PCW-1:0] pc;
        logic [XW-1:0]  imm;
        logic           exp_mis;
        logic [PCW-1:0] exp_op2;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    logic [31:0]    exp_cnt = 32'd0;
    logic [PCW-1:0] exp_op1 = '0;
    logic [PCW-1:0] exp_op2 = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_cnt();
`ifdef E203_BJP_MISPRED_CNT_EN
        exp_cnt = exp_cnt + 32'd1;
`endif
    endtask

    task automatic idle_inputs();
        i_valid      = 1'b0;
        i_bxx        = 1'b0;
        i_jump       = 1'b0;
        i_pred_taken = 1'b0;
        i_cmp_res    = 1'b0;
        i_rv32       = 1'b1;
        i_pc         = '0;
        i_imm        = '0;
    endtask

    task automatic drive(input logic bxx, input logic jump, input logic pred, input logic cmp,
                         input logic rv32, input logic [PCW-1:0] pc, input logic [XW-1:0] imm);
        i_valid      = 1'b1;
        i_bxx        = bxx;
        i_jump       = jump;
        i_pred_taken = pred;
        i_cmp_res    = cmp;
        i_rv32       = rv32;
        i_pc         = pc;
        i_imm        = imm;
    endtask

    task automatic chk_ops(input string tag);
        chk({tag, "_op1"}, 64'(pipe_flush_add_op1), 64'(exp_op1));
        chk({tag, "_op2"}, 64'(pipe_flush_add_op2), 64'(exp_op2));
        chk({tag, "_cnt"}, 64'(o_mispred_cnt), 64'(exp_cnt));
    endtask

    initial begin
        //        bxx   jump  pred  cmp   rv32  pc             imm            mis   op2
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0010, 32'h0000_0040, 1'b1, 32'h4};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFF0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0010, 1'b1, 32'h2};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0010, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0304, 32'h0000_0010, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0308, 32'h0000_0080, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_030C, 32'h0000_0080, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0020, 1'b1, 32'h20};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0020, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_0008, 1'b1, 32'h8};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0000_0008, 1'b1, 32'h2};

        rst_n          = 1'b0;
        pipe_flush_ack = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_req",     64'(pipe_flush_req), 64'd0);
        chk("rst_ready",   64'(i_ready),        64'd1);
        chk("rst_mispred", 64'(o_mispred),      64'd0);
        chk_ops("rst");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            chk($sformatf("v%0d_ready_pre", i), 64'(i_ready), 64'd1);
            drive(vecs[i].bxx, vecs[i].jump, vecs[i].pred, vecs[i].cmp,
                  vecs[i].rv32, vecs[i].pc, vecs[i].imm);
            tick();
            idle_inputs();
            if (vecs[i].exp_mis) begin
                exp_op1 = vecs[i].pc;
                exp_op2 = vecs[i].exp_op2;
                bump_cnt();
            end
            chk($sformatf("v%0d_req", i),     64'(pipe_flush_req), 64'(vecs[i].exp_mis));
            chk($sformatf("v%0d_mispred", i), 64'(o_mispred),      64'(vecs[i].exp_mis));
            chk($sformatf("v%0d_ready", i),   64'(i_ready),        64'(!vecs[i].exp_mis));
            chk_ops($sformatf("v%0d", i));
            if (vecs[i].exp_mis) begin
                pipe_flush_ack = 1'b1;
                tick();
                pipe_flush_ack = 1'b0;
                chk($sformatf("v%0d_post_req", i),     64'(pipe_flush_req), 64'd0);
                chk($sformatf("v%0d_post_ready", i),   64'(i_ready),        64'd1);
                chk($sformatf("v%0d_post_mispred", i), 64'(o_mispred),      64'd0);
            end
        end

        // Held redirect: ack low for three FLUSH cycles, a new branch offered mid-stall is ignored.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hFFFF_FFF0);
        tick();
        idle_inputs();
        exp_op1 = 32'h0000_0100;
        exp_op2 = 32'hFFFF_FFF0;
        bump_cnt();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall%0d_req", k),     64'(pipe_flush_req), 64'd1);
            chk($sformatf("stall%0d_ready", k),   64'(i_ready),        64'd0);
            chk($sformatf("stall%0d_mispred", k), 64'(o_mispred),      64'(k == 0));
            chk_ops($sformatf("stall%0d", k));
            if (k == 1) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0999, 32'h0000_0010);
            if (k == 3) pipe_flush_ack = 1'b1;
            tick();
            idle_inputs();
        end
        pipe_flush_ack = 1'b0;
        chk("stall_end_req",   64'(pipe_flush_req), 64'd0);
        chk("stall_end_ready", 64'(i_ready),        64'd1);
        chk_ops("stall_end");

        // Ack alone in IDLE does nothing.
        pipe_flush_ack = 1'b1;
        tick();
        chk("idle_ack_req",     64'(pipe_flush_req), 64'd0);
        chk("idle_ack_mispred", 64'(o_mispred),      64'd0);

        // Ack already high when the mispredict is accepted: one-cycle FLUSH.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0100);
        tick();
        idle_inputs();
        exp_op1 = 32'h0000_0040;
        exp_op2 = 32'h2;
        bump_cnt();
        chk("ackhi_req",     64'(pipe_flush_req), 64'd1);
        chk("ackhi_mispred", 64'(o_mispred),      64'd1);
        chk_ops("ackhi");
        tick();
        pipe_flush_ack = 1'b0;
        chk("ackhi_post_req",   64'(pipe_flush_req), 64'd0);
        chk("ackhi_post_ready", 64'(i_ready),        64'd1);

        // Back-to-back correct resolutions: jal then a correctly predicted bxx.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0700, 32'h0000_0100);
        tick();
        chk("b2b_jal_ready", 64'(i_ready),        64'd1);
        chk("b2b_jal_req",   64'(pipe_flush_req), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0704, 32'h0000_0100);
        tick();
        idle_inputs();
        chk("b2b_bxx_ready", 64'(i_ready),        64'd1);
        chk("b2b_bxx_req",   64'(pipe_flush_req), 64'd0);
        chk("b2b_mispred",   64'(o_mispred),      64'd0);
        chk_ops("b2b");

        // Reset while a redirect is pending.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0800, 32'h0000_0100);
        tick();
        idle_inputs();
        chk("rstfl_pre_req", 64'(pipe_flush_req), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        exp_cnt = 32'd0;
        exp_op1 = '0;
        exp_op2 = '0;
        chk("rstfl_req",     64'(pipe_flush_req), 64'd0);
        chk("rstfl_ready",   64'(i_ready),        64'd1);
        chk("rstfl_mispred", 64'(o_mispred),      64'd0);
        chk_ops("rstfl");

        // Three mispredicts after reset.
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, PCW'(32'h0000_0900 + 32'(j) * 32'h10), 32'h0000_0020);
            tick();
            idle_inputs();
            bump_cnt();
            pipe_flush_ack = 1'b1;
            tick();
            pipe_flush_ack = 1'b0;
        end
        exp_op1 = 32'h0000_0920;
        exp_op2 = 32'h0000_0020;
`ifdef E203_BJP_MISPRED_CNT_EN
        chk("cnt3_model", 64'(exp_cnt), 64'd3);
`endif
        chk_ops("cnt3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
